// File: rtl/data_pack_datapath_if.sv
// Handshake bundle for the 7-bit symbol packer: symbol input side, packed word
// output side, flush control and fill status.
interface data_pack_datapath_if #(
  parameter int unsigned SYM_W  = 7,
  parameter int unsigned WORD_W = 32
);
  logic [SYM_W-1:0]  sym_in;
  logic              sym_valid;
  logic              sym_ready;
  logic              flush;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;
  logic              flush_done;
  logic [5:0]        fill;

  modport master (
    output sym_in, sym_valid, flush, word_ready,
    input  sym_ready, word_out, word_valid, word_last, flush_done, fill
  );

  modport slave (
    input  sym_in, sym_valid, flush, word_ready,
    output sym_ready, word_out, word_valid, word_last, flush_done, fill
  );
endinterface

// File: rtl/data_pack_datapath.sv
// Packs 7-bit symbols LSB-first into contiguous 32-bit words through a 39-bit
// accumulator; a flush drains the partial tail as a zero-padded final word.
module data_pack_datapath #(
  parameter int unsigned SYM_W  = 7,
  parameter int unsigned WORD_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  data_pack_datapath_if.slave bus
);

  localparam int unsigned ACC_W = SYM_W + WORD_W;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [5:0]       fill_q, fill_d;
  logic [0:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;

  logic full;
  logic word_valid;
  logic sym_ready;
  logic pop;
  logic accept;

  assign full       = (fill_q >= 6'(WORD_W));
  assign word_valid = (state_q == ST_FILL) ? full : (fill_q != '0);
  assign pop        = word_valid & bus.word_ready;
  // word_ready lets a symbol in on the same cycle the full word leaves
  assign sym_ready  = (state_q == ST_FILL) & ~pend_q & (~full | bus.word_ready);
  assign accept     = bus.sym_valid & sym_ready;

  assign bus.sym_ready  = sym_ready;
  assign bus.word_valid = word_valid;
  assign bus.word_out   = acc_q[WORD_W-1:0];
  assign bus.word_last  = (state_q == ST_FLUSH) & (fill_q != '0);
  assign bus.flush_done = done_q;
  assign bus.fill       = fill_q;

  always_comb begin
    acc_d   = acc_q;
    fill_d  = fill_q;
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (pop) begin
          acc_d  = acc_q >> WORD_W;
          fill_d = fill_q - 6'(WORD_W);
        end
        // fill_d already reflects a same-cycle pop, so the symbol lands at fill-32
        if (accept) begin
          acc_d[fill_d +: SYM_W] = bus.sym_in;
          fill_d                 = fill_d + 6'(SYM_W);
        end
        if (bus.flush) begin
          pend_d = 1'b1;
        end
        if (pend_q && !full) begin
          state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (fill_q == '0) begin
          done_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_FILL;
        end else if (pop) begin
          acc_d   = '0;
          fill_d  = '0;
          done_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      fill_q  <= '0;
      state_q <= ST_FILL;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_data_pack_datapath.sv
// Scoreboard bench for data_pack_datapath: a bit-level packing model queues the
// expected words as symbols are accepted; a monitor checks each popped word.
module tb_data_pack_datapath;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;

  data_pack_datapath_if #(.SYM_W(7), .WORD_W(32)) bus ();

  data_pack_datapath #(.SYM_W(7), .WORD_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        q[$];
  exp_t        mon_e;
  logic [63:0] m_acc;
  int unsigned m_fill;

  int          pops         = 0;
  int          fd_cnt       = 0;
  int          fd_cyc       = -1;
  int          last_pop_cyc = -1;
  int          valid_cnt    = 0;
  logic [31:0] last_word;
  logic        last_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: word pops, flush_done pulses and the fill bound
  always @(negedge clk) begin
    if (rst) begin
      if (bus.word_valid && bus.word_ready) begin
        pops++;
        last_pop_cyc = cyc;
        last_word    = bus.word_out;
        last_last    = bus.word_last;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got %h last=%b, none expected", bus.word_out, bus.word_last);
        end else begin
          mon_e = q.pop_front();
          if (bus.word_out !== mon_e.data || bus.word_last !== mon_e.last) begin
            errors++;
            $display("FAIL word: got %h last=%b, expected %h last=%b",
                     bus.word_out, bus.word_last, mon_e.data, mon_e.last);
          end
        end
      end
      if (bus.flush_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (bus.word_valid) valid_cnt++;
      checks++;
      if (bus.fill > 6'd38) begin
        errors++;
        $display("FAIL fill_bound: got %0d, expected <= 38", bus.fill);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q.delete();
    m_acc  = '0;
    m_fill = 0;
  endtask

  task automatic model_accept(input logic [6:0] s);
    exp_t e;
    m_acc  = m_acc | (64'(s) << m_fill);
    m_fill = m_fill + 7;
    if (m_fill >= 32) begin
      e.data = m_acc[31:0];
      e.last = 1'b0;
      q.push_back(e);
      m_acc  = m_acc >> 32;
      m_fill = m_fill - 32;
    end
  endtask

  task automatic model_flush();
    exp_t e;
    if (m_fill > 0) begin
      e.data = m_acc[31:0];
      e.last = 1'b1;
      q.push_back(e);
    end
    m_acc  = '0;
    m_fill = 0;
  endtask

  task automatic apply_reset();
    rst            = 1'b0;
    bus.sym_valid  = 1'b0;
    bus.sym_in     = '0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge
  task automatic send_sym(input logic [6:0] s, output bit stalled);
    bit got;
    got     = 1'b0;
    stalled = 1'b0;
    bus.sym_valid = 1'b1;
    bus.sym_in    = s;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.sym_ready) begin
        model_accept(s);
        got = 1'b1;
      end else begin
        stalled = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.sym_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL sym_accept_timeout: symbol %h not accepted in 50 cycles", s);
    end
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    model_flush();
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic wait_flush_done(input int fd0);
    for (int i = 0; i < 30 && fd_cnt == fd0; i++) begin
      @(posedge clk);
      #1;
    end
    if (fd_cnt == fd0) begin
      checks++;
      errors++;
      $display("FAIL flush_done_timeout: no pulse in 30 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words still expected", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    bus.sym_valid  = 1'b0;
    bus.sym_in     = '0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.word_valid !== 1'b0 || bus.word_last !== 1'b0 || bus.flush_done !== 1'b0 ||
        bus.sym_ready !== 1'b1 || bus.fill !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: got wv=%b wl=%b fd=%b sr=%b fill=%0d, expected 0 0 0 1 0",
               bus.word_valid, bus.word_last, bus.flush_done, bus.sym_ready, bus.fill);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bit st;
    apply_reset();
    for (int i = 1; i <= 5; i++) send_sym(7'(i), st);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h5080C101) begin
      errors++;
      $display("FAIL basic_word: got wv=%b word=%h, expected wv=1 word=5080c101",
               bus.word_valid, bus.word_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.fill !== 6'd3) begin
      errors++;
      $display("FAIL basic_fill: got %0d, expected 3", bus.fill);
    end
  endtask

  task automatic test_back_to_back();
    bit st;
    bit any_stall;
    int p0;
    apply_reset();
    p0        = pops;
    any_stall = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send_sym(7'h7F, st);
      any_stall |= st;
    end
    wait_drain();
    checks++;
    if (any_stall) begin
      errors++;
      $display("FAIL b2b_stall: got sym_ready drop, expected none");
    end
    checks++;
    if (pops - p0 != 7) begin
      errors++;
      $display("FAIL b2b_words: got %0d, expected 7", pops - p0);
    end
    checks++;
    if (bus.fill !== 6'd0) begin
      errors++;
      $display("FAIL b2b_fill: got %0d, expected 0", bus.fill);
    end
  endtask

  task automatic test_flush_partial();
    bit st;
    int fd0, p0;
    apply_reset();
    for (int i = 0; i < 3; i++) send_sym(7'h7F, st);
    fd0 = fd_cnt;
    p0  = pops;
    pulse_flush();
    wait_flush_done(fd0);
    checks++;
    if (pops - p0 != 1 || last_word !== 32'h001FFFFF || last_last !== 1'b1) begin
      errors++;
      $display("FAIL flush_partial_word: got n=%0d word=%h last=%b, expected n=1 word=001fffff last=1",
               pops - p0, last_word, last_last);
    end
    checks++;
    if (fd_cnt - fd0 != 1 || fd_cyc != last_pop_cyc + 1) begin
      errors++;
      $display("FAIL flush_partial_done: got pulses=%0d at cyc %0d, expected 1 at cyc %0d",
               fd_cnt - fd0, fd_cyc, last_pop_cyc + 1);
    end
    checks++;
    if (bus.fill !== 6'd0 || bus.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_partial_fill: got fill=%0d wv=%b, expected 0 0", bus.fill, bus.word_valid);
    end
  endtask

  task automatic test_backpressure();
    bit st;
    logic [31:0] held;
    bit moved;
    apply_reset();
    bus.word_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_sym(7'h11 + 7'(i * 13), st);
    @(negedge clk);
    checks++;
    if (bus.sym_ready !== 1'b0 || bus.fill !== 6'd35 || bus.word_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got sr=%b fill=%0d wv=%b, expected 0 35 1",
               bus.sym_ready, bus.fill, bus.word_valid);
    end
    held          = bus.word_out;
    moved         = 1'b0;
    bus.sym_valid = 1'b1;
    bus.sym_in    = 7'h2A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.word_out !== held || bus.sym_ready !== 1'b0) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL bp_hold: got word=%h sr=%b, expected word=%h sr=0", bus.word_out, bus.sym_ready, held);
    end
    @(posedge clk);
    #1;
    bus.word_ready = 1'b1;
    #1;
    checks++;
    if (bus.sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, expected 1", bus.sym_ready);
    end
    model_accept(7'h2A);
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
    checks++;
    if (bus.fill !== 6'd10) begin
      errors++;
      $display("FAIL bp_fill: got %0d, expected 10", bus.fill);
    end
  endtask

  task automatic test_flush_empty();
    int fd0, v0;
    apply_reset();
    fd0 = fd_cnt;
    v0  = valid_cnt;
    pulse_flush();
    wait_flush_done(fd0);
    checks++;
    if (fd_cnt - fd0 != 1 || valid_cnt != v0) begin
      errors++;
      $display("FAIL flush_empty: got pulses=%0d valid_cycles=%0d, expected 1 0",
               fd_cnt - fd0, valid_cnt - v0);
    end
  endtask

  task automatic test_flush_full();
    bit st;
    int fd0, p0;
    apply_reset();
    bus.word_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_sym(7'h5A ^ 7'(i * 9), st);
    fd0 = fd_cnt;
    p0  = pops;
    pulse_flush();
    bus.word_ready = 1'b1;
    wait_flush_done(fd0);
    checks++;
    if (pops - p0 != 2 || last_last !== 1'b1 || fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL flush_full: got words=%0d last=%b pulses=%0d, expected 2 1 1",
               pops - p0, last_last, fd_cnt - fd0);
    end
    checks++;
    if (bus.fill !== 6'd0 || q.size() != 0) begin
      errors++;
      $display("FAIL flush_full_fill: got fill=%0d pending=%0d, expected 0 0", bus.fill, q.size());
    end
  endtask

  task automatic test_async_reset();
    bit st;
    apply_reset();
    for (int i = 1; i <= 7; i++) send_sym(7'(i), st);
    checks++;
    if (bus.fill !== 6'd17 || bus.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_pre: got fill=%0d wv=%b, expected 17 0", bus.fill, bus.word_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.fill !== 6'd0 || bus.word_valid !== 1'b0 || bus.word_last !== 1'b0 ||
        bus.flush_done !== 1'b0 || bus.sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: got fill=%0d wv=%b wl=%b fd=%b sr=%b, expected 0 0 0 0 1",
               bus.fill, bus.word_valid, bus.word_last, bus.flush_done, bus.sym_ready);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) send_sym(7'(i), st);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h5080C101) begin
      errors++;
      $display("FAIL areset_replay: got wv=%b word=%h, expected wv=1 word=5080c101",
               bus.word_valid, bus.word_out);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush_partial();
    test_backpressure();
    test_flush_empty();
    test_flush_full();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_pack_datapath.md
Name: data_pack_datapath

Overview:
- Upstream stage of the 7-bit packet path: accepts a stream of 7-bit symbols and packs them contiguously, LSB-first, into 32-bit words for the word line.
- Symbols straddle word boundaries with no padding, so the unpacker regenerates the identical symbol sequence.
- Valid/ready handshakes on both sides; a flush request drains a partial final word, zero-padded.

Parameters:
- SYM_W, 7, symbol width in bits (fixed at 7 in this design; parameter documents intent only).
- WORD_W, 32, output word width in bits (fixed at 32).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-low reset (asserted when 0).
- sym_in  input  7  symbol data.
- sym_valid  input  1  sym_in is valid this cycle.
- sym_ready  output  1  block accepts sym_in this cycle.
- flush  input  1  one-cycle request to drain remaining bits.
- word_out  output  32  packed word.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  downstream accepts word_out.
- word_last  output  1  qualifies word_out as the final, zero-padded word of a flush.
- flush_done  output  1  one-cycle pulse when a flush completes.
- fill  output  6  bits currently held in the accumulator (0..38), for status/debug.

Behaviour:
- Storage: 39-bit accumulator acc (LSB = oldest bit) plus 6-bit fill count.
- Reset (rst=0, async) values: acc=0, fill=0, state=FILL, word_valid=0, word_last=0, flush_done=0, sym_ready=1. Reset mid-operation discards all held bits; no partial word is emitted.
- Symbol accept when sym_valid & sym_ready: acc[fill +: 7] <= sym_in; fill <= fill + 7 (combined with any same-cycle pop below).
- Word complete: word_valid=1 whenever fill >= 32 (state FILL), or the padded word is pending (state FLUSH). word_out = acc[31:0]; all bits at index >= fill read 0.
- Word pop on word_valid & word_ready: acc >>= 32 (zero-fill), fill -= 32. After a padded-word pop, fill = 0 and acc = 0.
- Simultaneous pop and accept: the new symbol lands at position (fill-32). Resulting fill = fill - 25, which is <= 13.
- sym_ready = (state==FILL) & ~flush_pending & ((fill < 32) | word_ready). The word_ready term is the only combinational input-to-output path.
- word_valid and word_out are pure functions of registers; word_out stays stable while word_valid=1 and word_ready=0.
- Flush request:
  - flush is sampled every cycle and sets flush_pending.
  - A flush arriving in the same cycle as an accepted symbol applies after that symbol.
  - A flush while flush_pending or in state FLUSH is ignored.
- State FILL to FLUSH when flush_pending & fill < 32.
  - If fill == 0: no word emitted; flush_done pulses on the next cycle; return to FILL.
  - If fill in 1..31: emit acc[31:0] zero-padded with word_last=1. On pop, pulse flush_done for one cycle; clear flush_pending; return to FILL.
- While fill >= 32 with flush_pending, the full word drains first (word_last=0), then the rule above applies to the remainder.
- Alignment: 32 symbols = 224 bits = exactly 7 words; fill returns to 0 after each 32-symbol group.
- No overflow is possible: fill <= 38 by construction. An assertion in the bench checks fill never exceeds 38.

Test Plan:
- Reset then symbols 0x01,0x02,0x03,0x04,0x05, word_ready=1 -> word_out=0x5080C101 with word_valid one cycle after 5th accept; fill=3 after pop.
- 32 symbols of 0x7F back-to-back, word_ready=1 -> exactly 7 words of 0xFFFFFFFF, sym_ready never drops, final fill=0, word_last never set.
- 3 symbols of 0x7F then flush -> one word 0x001FFFFF with word_last=1; flush_done pulses on its pop; fill=0.
- word_ready=0 with fill reaching 35 -> sym_ready=0, word_out held stable across 10 cycles. Raise word_ready with sym_valid=1 -> pop and accept in the same cycle; fill=10.
- Flush with fill=0 -> no word_valid, flush_done single pulse. Flush with fill=35 -> full word (word_last=0), then padded 3-bit word (word_last=1).
- Assert rst=0 asynchronously mid-word (fill=17, word_valid=0) -> all outputs at reset values immediately. Next symbols 0x01.. reproduce the first scenario's 0x5080C101.
